// File: rtl/user_input_debounce.sv
// Synchronizes, debounces and edge-detects the active-low buttons/DIP switches on clk_50.
// Define USER_INPUT_LONG_PRESS_EN to build per-input hold counters driving long_press.
`timescale 1ns/1ps

module user_input_debounce #(
  parameter int unsigned N_INPUTS       = 5,
  parameter int unsigned TICK_CYCLES    = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned LONG_TICKS     = 1000
) (
  input  logic                clk_50,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] in_n,
  output logic [N_INPUTS-1:0] state,
  output logic [N_INPUTS-1:0] press,
  output logic [N_INPUTS-1:0] release_pulse,
  output logic [7:0]          event_count,
  output logic [N_INPUTS-1:0] long_press
);

  localparam int unsigned PresW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned DebW  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [PresW-1:0] PresReload = PresW'(TICK_CYCLES - 1);
  localparam logic [DebW-1:0]  DebLast    = DebW'(DEBOUNCE_TICKS - 1);

  logic [N_INPUTS-1:0]            sync1_q, sync2_q;
  logic [N_INPUTS-1:0]            s;
  logic [PresW-1:0]               presc_q, presc_d;
  logic                           tick;
  logic [N_INPUTS-1:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [N_INPUTS-1:0]            state_q, state_d, state_dly_q;
  logic [N_INPUTS-1:0]            press_q, release_q;
  logic [7:0]                     event_count_q, event_count_d;
  logic [7:0]                     press_sum;

  assign s    = ~sync2_q;
  assign tick = (presc_q == '0);

  always_comb begin
    presc_d = tick ? PresReload : presc_q - 1'b1;
  end

  // Counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      if (s[i] == state_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (tick) begin
        if (deb_cnt_q[i] == DebLast) begin
          state_d[i]   = ~state_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press_sum = '0;
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      press_sum = press_sum + 8'(press_q[i]);
    end
    event_count_d = event_count_q + press_sum;
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      presc_q       <= PresReload;
      deb_cnt_q     <= '0;
      state_q       <= '0;
      state_dly_q   <= '0;
      press_q       <= '0;
      release_q     <= '0;
      event_count_q <= '0;
    end else begin
      sync1_q       <= in_n;
      sync2_q       <= sync1_q;
      presc_q       <= presc_d;
      deb_cnt_q     <= deb_cnt_d;
      state_q       <= state_d;
      state_dly_q   <= state_q;
      press_q       <= state_q & ~state_dly_q;
      release_q     <= ~state_q & state_dly_q;
      event_count_q <= event_count_d;
    end
  end

  assign state         = state_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign event_count   = event_count_q;

`ifdef USER_INPUT_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_TICKS);
  localparam logic [HoldW-1:0] HoldPre = HoldW'(LONG_TICKS - 1);

  logic [N_INPUTS-1:0][HoldW-1:0] hold_q, hold_d;
  logic [N_INPUTS-1:0]            long_q, long_d;

  // Saturating at HoldMax is what suppresses repeats until the input is released.
  always_comb begin
    hold_d = hold_q;
    long_d = '0;
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      if (!state_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && (hold_q[i] != HoldMax)) begin
        hold_d[i] = hold_q[i] + 1'b1;
        long_d[i] = (hold_q[i] == HoldPre);
      end
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_user_input_debounce.sv
// Self-checking bench for user_input_debounce: vector table plus pulse scoreboard.
`timescale 1ns/1ps

module tb_user_input_debounce;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] in_n = 5'b11111;
  logic [4:0] state, press, release_pulse, long_press;
  logic [7:0] event_count;

  always #5 clk_50 = ~clk_50;

  user_input_debounce #(
    .N_INPUTS      (5),
    .TICK_CYCLES   (4),
    .DEBOUNCE_TICKS(3),
    .LONG_TICKS    (5)
  ) dut (
    .clk_50       (clk_50),
    .reset        (reset),
    .in_n         (in_n),
    .state        (state),
    .press        (press),
    .release_pulse(release_pulse),
    .event_count  (event_count),
    .long_press   (long_press)
  );

  typedef struct packed {
    logic [4:0] pr;
    logic [4:0] rl;
    logic [4:0] lg;
  } pulse_t;

  typedef struct {
    logic [4:0] in_n;
    logic [4:0] st;
    logic [4:0] pr;
    logic [4:0] rl;
    logic [4:0] lg;
  } vec_t;

  pulse_t     exp_q[$];
  vec_t       vecs[8];
  int         checks = 0;
  int         passes = 0;
  int         rel2_seen = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic expect_pulse(input logic [4:0] pr, input logic [4:0] rl, input logic [4:0] lg);
    pulse_t e;
    if ((pr | rl | lg) != 5'b0) begin
      e.pr = pr;
      e.rl = rl;
      e.lg = lg;
      exp_q.push_back(e);
      exp_cnt = exp_cnt + 8'($countones(pr));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50);
  endtask

  task automatic wait_state(input logic [4:0] req, input string name);
    int n;
    n = 0;
    while (state !== req && n < 30) begin
      @(posedge clk_50);
      #1;
      n++;
    end
    check(name, state, req);
    check({name, " latency<=15"}, 32'(n <= 15), 1);
  endtask

  // Scoreboard: every cycle carrying a pulse must match the oldest expectation.
  always @(negedge clk_50) begin
    pulse_t e;
    if (!reset && ((press | release_pulse | long_press) != 5'b0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected pulse", {press, release_pulse, long_press}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse {press,release,long}", {press, release_pulse, long_press}, e);
      end
    end
    if (!reset && release_pulse[2]) rel2_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{5'b11110, 5'b00001, 5'b00001, 5'b00000, 5'b00001};
    vecs[1] = '{5'b11111, 5'b00000, 5'b00000, 5'b00001, 5'b00000};
    vecs[2] = '{5'b11100, 5'b00011, 5'b00011, 5'b00000, 5'b00011};
    vecs[3] = '{5'b11101, 5'b00010, 5'b00000, 5'b00001, 5'b00000};
    vecs[4] = '{5'b11111, 5'b00000, 5'b00000, 5'b00010, 5'b00000};
    vecs[5] = '{5'b01111, 5'b10000, 5'b10000, 5'b00000, 5'b10000};
    vecs[6] = '{5'b01110, 5'b10001, 5'b00001, 5'b00000, 5'b00001};
    vecs[7] = '{5'b11111, 5'b00000, 5'b00000, 5'b10001, 5'b00000};

    cyc(3);
    #1;
    check("reset state", state, 0);
    check("reset event_count", event_count, 0);
    check("reset pulses", {press, release_pulse, long_press}, 0);
    @(negedge clk_50);
    reset = 1'b0;

    cyc(100);
    @(negedge clk_50);
    check("idle state", state, 0);
    check("idle event_count", event_count, 0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk_50);
      in_n = vecs[i].in_n;
      expect_pulse(vecs[i].pr, vecs[i].rl, 5'b0);
`ifdef USER_INPUT_LONG_PRESS_EN
      expect_pulse(5'b0, 5'b0, vecs[i].lg);
`endif
      wait_state(vecs[i].st, "vec state");
      cyc(30);
      check("vec event_count", event_count, exp_cnt);
      check("vec scoreboard drained", exp_q.size(), 0);
    end

    // Glitch shorter than three ticks on bit 1.
    @(negedge clk_50);
    in_n[1] = 1'b0;
    repeat (5) @(negedge clk_50);
    in_n[1] = 1'b1;
    cyc(30);
    check("glitch state", state, 0);
    check("glitch event_count", event_count, exp_cnt);

`ifdef USER_INPUT_LONG_PRESS_EN
    @(negedge clk_50);
    in_n = 5'b01111;
    expect_pulse(5'b10000, 5'b0, 5'b0);
    expect_pulse(5'b0, 5'b0, 5'b10000);
    wait_state(5'b10000, "long state");
    n = 0;
    while (!long_press[4] && n < 40) begin
      @(posedge clk_50);
      #1;
      n++;
    end
    check("long_press delay", n, 20);
    cyc(30);
    @(negedge clk_50);
    in_n = 5'b11111;
    expect_pulse(5'b0, 5'b10000, 5'b0);
    wait_state(5'b0, "long release state");
    cyc(5);
`endif

    // Reset while bit 3 is mid-debounce and bit 0 is already accepted.
    @(negedge clk_50);
    in_n = 5'b11110;
    expect_pulse(5'b00001, 5'b0, 5'b0);
`ifdef USER_INPUT_LONG_PRESS_EN
    expect_pulse(5'b0, 5'b0, 5'b00001);
`endif
    wait_state(5'b00001, "pre-reset state");
    cyc(30);
    @(negedge clk_50);
    in_n = 5'b10110;
    cyc(8);
    #2;
    reset = 1'b1;
    #1;
    check("async reset state", state, 0);
    check("async reset event_count", event_count, 0);
    check("async reset pulses", {press, release_pulse, long_press}, 0);
    exp_q.delete();
    exp_cnt = 8'd0;
    @(negedge clk_50);
    reset = 1'b0;
    expect_pulse(5'b01001, 5'b0, 5'b0);
`ifdef USER_INPUT_LONG_PRESS_EN
    expect_pulse(5'b0, 5'b0, 5'b01001);
`endif
    n = 0;
    while (state[3] !== 1'b1 && n < 30) begin
      @(posedge clk_50);
      #1;
      n++;
    end
    check("restart latency", n, 12);
    check("restart state", state, 5'b01001);
    cyc(30);
    check("restart event_count", event_count, exp_cnt);
    @(negedge clk_50);
    in_n = 5'b11111;
    expect_pulse(5'b0, 5'b01001, 5'b0);
    wait_state(5'b0, "restart release state");
    cyc(5);

    // DIP switch already ON across reset counts as a press.
    @(negedge clk_50);
    reset = 1'b1;
    in_n = 5'b11011;
    exp_q.delete();
    exp_cnt = 8'd0;
    cyc(2);
    @(negedge clk_50);
    reset = 1'b0;
    expect_pulse(5'b00100, 5'b0, 5'b0);
`ifdef USER_INPUT_LONG_PRESS_EN
    expect_pulse(5'b0, 5'b0, 5'b00100);
`endif
    wait_state(5'b00100, "dip state");
    cyc(30);
    check("dip event_count", event_count, 8'd1);
    @(negedge clk_50);
    in_n = 5'b11111;
    expect_pulse(5'b0, 5'b00100, 5'b0);
    wait_state(5'b0, "dip release state");
    cyc(5);

    // 257 press/release cycles on bit 2 from a fresh reset: count wraps to 1.
    @(negedge clk_50);
    reset = 1'b1;
    exp_q.delete();
    exp_cnt = 8'd0;
    cyc(2);
    @(negedge clk_50);
    reset = 1'b0;
    rel2_seen = 0;
    for (int k = 0; k < 257; k++) begin
      @(negedge clk_50);
      in_n[2] = 1'b0;
      expect_pulse(5'b00100, 5'b0, 5'b0);
      wait_state(5'b00100, "wrap press state");
      @(negedge clk_50);
      in_n[2] = 1'b1;
      expect_pulse(5'b0, 5'b00100, 5'b0);
      wait_state(5'b0, "wrap release state");
      cyc(3);
    end
    cyc(10);
    check("wrap event_count", event_count, 8'd1);
    check("wrap model event_count", event_count, exp_cnt);
    check("wrap release pulses", rel2_seen, 257);
    check("final scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
